// File: rtl/sd_weight_loader.sv
// SD-card weight loader: reads a run of 512-byte sectors, packs the byte stream
// into DATA_W-bit words and writes them round-robin across NUM_BANKS weight banks.
module sd_weight_loader #(
  parameter int DATA_W     = 32,
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_W     = 10,
  parameter int BYTE_ORDER = 0,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       start_sector,
  input  logic [31:0]       word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              sd_init_done,
  output logic              sd_sec_read,
  output logic [31:0]       sd_sec_read_addr,
  input  logic [7:0]        sd_sec_read_data,
  input  logic              sd_sec_read_data_valid,
  input  logic              sd_sec_read_end,
  output logic              wr_en,
  output logic [BANK_W-1:0] wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int BYTES = DATA_W / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [63:0] CAP = 64'(NUM_BANKS) << ADDR_W;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);

  typedef enum logic [2:0] {IDLE, REQ, XFER, GAP, FIN} state_t;

  state_t              state, state_nxt;
  logic                err_nxt;
  logic [39:0]         total_bytes, total_bytes_in, byte_cnt;
  logic [31:0]         sectors, sec_idx;
  logic [LANE_W-1:0]   lane;
  logic [BANK_W-1:0]   bank_cnt;
  logic [ADDR_W-1:0]   addr_cnt;
  logic                abort_seen;
  logic [DATA_W-1:0]   pack, pack_merged;
  logic                accept, count_ok, byte_in, byte_keep, word_done;

  function automatic logic [31:0] sectors_for(input logic [39:0] nbytes);
    return {1'b0, nbytes[39:9]} + {31'd0, |nbytes[8:0]};
  endfunction

  assign accept         = (state == IDLE) && start && sd_init_done;
  assign count_ok       = (word_count != 32'd0) && (64'(word_count) <= CAP);
  assign total_bytes_in = 40'(word_count) * 40'(BYTES);
  assign byte_in        = (state == XFER) && sd_sec_read_data_valid;
  assign byte_keep      = byte_in && (byte_cnt < total_bytes);
  assign word_done      = byte_keep && (lane == LANE_LAST);

  // Shift-in packing: after BYTES shifts the first byte sits at its final lane.
  generate
    if (DATA_W == 8) begin : g_pack_byte
      assign pack_merged = sd_sec_read_data;
    end else if (BYTE_ORDER == 0) begin : g_pack_le
      assign pack_merged = {sd_sec_read_data, pack[DATA_W-1:8]};
    end else begin : g_pack_be
      assign pack_merged = {pack[DATA_W-9:0], sd_sec_read_data};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nxt = count_ok ? REQ : FIN;
        err_nxt   = !count_ok;
      end
      REQ:  state_nxt = XFER;
      XFER: if (sd_sec_read_end) state_nxt = GAP;
      GAP: begin
        if (abort_seen || abort) begin
          state_nxt = FIN;
          err_nxt   = 1'b1;
        end else if ((sec_idx + 32'd1) < sectors) begin
          state_nxt = REQ;
        end else begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      sd_sec_read      <= 1'b0;
      sd_sec_read_addr <= 32'd0;
      wr_en            <= 1'b0;
      wr_bank          <= '0;
      wr_addr          <= '0;
      wr_data          <= '0;
      total_bytes      <= 40'd0;
      byte_cnt         <= 40'd0;
      sectors          <= 32'd0;
      sec_idx          <= 32'd0;
      lane             <= '0;
      bank_cnt         <= '0;
      addr_cnt         <= '0;
      abort_seen       <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt == REQ) || (state_nxt == XFER) || (state_nxt == GAP);
      done        <= (state_nxt == FIN);
      err         <= (state_nxt == FIN) && err_nxt;
      sd_sec_read <= (state_nxt == REQ) || (state_nxt == XFER);
      wr_en       <= word_done;

      if (accept) begin
        sd_sec_read_addr <= start_sector;
        total_bytes      <= total_bytes_in;
        sectors          <= sectors_for(total_bytes_in);
        byte_cnt         <= 40'd0;
        sec_idx          <= 32'd0;
        lane             <= '0;
        bank_cnt         <= '0;
        addr_cnt         <= '0;
        abort_seen       <= abort;
      end else if (state != IDLE && abort) begin
        abort_seen <= 1'b1;
      end

      if (state == GAP) begin
        sec_idx          <= sec_idx + 32'd1;
        sd_sec_read_addr <= sd_sec_read_addr + 32'd1;
      end

      if (byte_in) byte_cnt <= byte_cnt + 40'd1;
      if (byte_keep) lane <= word_done ? '0 : lane + 1'b1;

      if (word_done) begin
        wr_data <= pack_merged;
        wr_bank <= bank_cnt;
        wr_addr <= addr_cnt;
        if (bank_cnt == BANK_LAST) begin
          bank_cnt <= '0;
          addr_cnt <= addr_cnt + 1'b1;
        end else begin
          bank_cnt <= bank_cnt + 1'b1;
        end
      end
    end
  end

  // Pack register carries only data, so it needs no reset.
  always_ff @(posedge clk) begin
    if (byte_keep) pack <= pack_merged;
  end

endmodule

// File: tb/tb_sd_weight_loader.sv
// Directed bench for sd_weight_loader: a 32-bit little-endian instance and a
// 24-bit MSB-first instance share one behavioural SD byte source.
module tb_sd_weight_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, abort, sd_init_done;
  logic [31:0] start_sector, word_count;
  logic [7:0]  sd_data;
  logic        sd_valid, sd_end;

  logic        busy_a, done_a, err_a, rd_a, wr_en_a;
  logic [31:0] rda_a, wdata_a;
  logic [1:0]  bank_a;
  logic [9:0]  waddr_a;

  logic        busy_b, done_b, err_b, rd_b, wr_en_b;
  logic [31:0] rda_b;
  logic [23:0] wdata_b;
  logic [1:0]  bank_b;
  logic [9:0]  waddr_b;

  sd_weight_loader #(.DATA_W(32), .NUM_BANKS(4), .ADDR_W(10), .BYTE_ORDER(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .start_sector(start_sector),
    .word_count(word_count), .abort(abort), .busy(busy_a), .done(done_a), .err(err_a),
    .sd_init_done(sd_init_done), .sd_sec_read(rd_a), .sd_sec_read_addr(rda_a),
    .sd_sec_read_data(sd_data), .sd_sec_read_data_valid(sd_valid),
    .sd_sec_read_end(sd_end), .wr_en(wr_en_a), .wr_bank(bank_a), .wr_addr(waddr_a),
    .wr_data(wdata_a)
  );

  sd_weight_loader #(.DATA_W(24), .NUM_BANKS(4), .ADDR_W(10), .BYTE_ORDER(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .start_sector(start_sector),
    .word_count(word_count), .abort(abort), .busy(busy_b), .done(done_b), .err(err_b),
    .sd_init_done(sd_init_done), .sd_sec_read(rd_b), .sd_sec_read_addr(rda_b),
    .sd_sec_read_data(sd_data), .sd_sec_read_data_valid(sd_valid),
    .sd_sec_read_end(sd_end), .wr_en(wr_en_b), .wr_bank(bank_b), .wr_addr(waddr_b),
    .wr_data(wdata_b)
  );

  int total = 0;
  int bad   = 0;

  bit          use_b = 1'b0;
  int          rises, low_run, gap_last, n_wr, done_cnt;
  logic        err_last, rd_prev;
  logic [31:0] rd_addr_log [0:7];
  logic [31:0] wd_log [0:511];
  logic [1:0]  wb_log [0:511];
  logic [9:0]  wa_log [0:511];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Monitor of the selected instance, sampled on the falling edge
  always @(negedge clk) begin
    logic r;
    r = use_b ? rd_b : rd_a;
    if (r) begin
      if (!rd_prev) begin
        if (rises < 8) rd_addr_log[rises] = use_b ? rda_b : rda_a;
        if (rises > 0) gap_last = low_run;
        rises++;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    rd_prev = r;
    if (use_b ? wr_en_b : wr_en_a) begin
      if (n_wr < 512) begin
        wd_log[n_wr] = use_b ? {8'h00, wdata_b} : wdata_a;
        wb_log[n_wr] = use_b ? bank_b : bank_a;
        wa_log[n_wr] = use_b ? waddr_b : waddr_a;
      end
      n_wr++;
    end
    if (use_b ? done_b : done_a) begin
      done_cnt++;
      err_last = use_b ? err_b : err_a;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs;
    rises = 0; low_run = 0; gap_last = -1; n_wr = 0; done_cnt = 0;
    err_last = 1'b0; rd_prev = 1'b0;
  endtask

  task automatic do_start(input bit b, input logic [31:0] sec, input logic [31:0] cnt);
    use_b = b;
    start_sector = sec;
    word_count = cnt;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    tick;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Serves 512-byte sectors (byte value = stream index mod 256) until done
  task automatic serve(input int abort_byte);
    int cyc;
    int g;
    cyc = 0;
    g = 0;
    while (done_cnt == 0 && cyc < 6000) begin
      tick;
      cyc++;
      if (use_b ? rd_b : rd_a) begin
        tick;
        for (int i = 0; i < 512; i++) begin
          sd_valid = 1'b1;
          sd_data  = g[7:0];
          abort    = (g == abort_byte);
          g++;
          tick;
        end
        sd_valid = 1'b0;
        abort    = 1'b0;
        sd_end   = 1'b1;
        tick;
        sd_end   = 1'b0;
        cyc += 514;
      end
    end
    check("done_timeout", 64'(done_cnt != 0), 64'd1);
  endtask

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; sd_init_done = 1'b1;
    start_sector = 32'd0; word_count = 32'd0; sd_data = 8'd0; sd_valid = 1'b0; sd_end = 1'b0;
    clr_logs;
    tick; tick;
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_rd", 64'(rd_a), 64'd0);
    check("rst_addr", 64'(rda_a), 64'd0);
    check("rst_wr_en", 64'(wr_en_a), 64'd0);
    check("rst_wr_data", 64'(wdata_a), 64'd0);
    rst = 1'b1;
    tick; tick;

    // One full sector, 128 words
    clr_logs;
    do_start(1'b0, 32'd100, 32'd128);
    check("t1_rd_at_t1", 64'(rd_a), 64'd1);
    check("t1_addr_at_t1", 64'(rda_a), 64'd100);
    check("t1_busy", 64'(busy_a), 64'd1);
    serve(-1);
    tick; tick;
    check("t1_reads", 64'(rises), 64'd1);
    check("t1_rd_addr", 64'(rd_addr_log[0]), 64'd100);
    check("t1_nwr", 64'(n_wr), 64'd128);
    check("t1_w0", 64'(wd_log[0]), 64'h03020100);
    check("t1_w0_bank", 64'(wb_log[0]), 64'd0);
    check("t1_w0_addr", 64'(wa_log[0]), 64'd0);
    check("t1_w5", 64'(wd_log[5]), 64'h17161514);
    check("t1_w5_bank", 64'(wb_log[5]), 64'd1);
    check("t1_w5_addr", 64'(wa_log[5]), 64'd1);
    check("t1_w127", 64'(wd_log[127]), 64'hFFFEFDFC);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_err", 64'(err_last), 64'd0);
    check("t1_busy_end", 64'(busy_a), 64'd0);

    // Two sectors, tail of the second discarded
    clr_logs;
    do_start(1'b0, 32'd100, 32'd200);
    serve(-1);
    tick; tick;
    check("t2_reads", 64'(rises), 64'd2);
    check("t2_rd_addr0", 64'(rd_addr_log[0]), 64'd100);
    check("t2_rd_addr1", 64'(rd_addr_log[1]), 64'd101);
    check("t2_gap", 64'(gap_last), 64'd1);
    check("t2_nwr", 64'(n_wr), 64'd200);
    check("t2_w128", 64'(wd_log[128]), 64'h03020100);
    check("t2_w199", 64'(wd_log[199]), 64'h1F1E1D1C);
    check("t2_w199_bank", 64'(wb_log[199]), 64'd3);
    check("t2_w199_addr", 64'(wa_log[199]), 64'd49);
    check("t2_err", 64'(err_last), 64'd0);

    // 24-bit MSB-first, word 170 spans the sector boundary
    clr_logs;
    do_start(1'b1, 32'd7, 32'd171);
    serve(-1);
    tick; tick;
    check("t3_reads", 64'(rises), 64'd2);
    check("t3_rd_addr1", 64'(rd_addr_log[1]), 64'd8);
    check("t3_nwr", 64'(n_wr), 64'd171);
    check("t3_w0", 64'(wd_log[0]), 64'h000102);
    check("t3_w170", 64'(wd_log[170]), 64'hFEFF00);
    check("t3_w170_bank", 64'(wb_log[170]), 64'd2);
    check("t3_w170_addr", 64'(wa_log[170]), 64'd42);
    check("t3_err", 64'(err_last), 64'd0);

    // Rejections
    clr_logs;
    do_start(1'b0, 32'd100, 32'd0);
    check("rej0_done", 64'(done_a), 64'd1);
    check("rej0_err", 64'(err_a), 64'd1);
    check("rej0_rd", 64'(rd_a), 64'd0);
    tick; tick; tick;
    check("rej0_reads", 64'(rises), 64'd0);
    check("rej0_done_cnt", 64'(done_cnt), 64'd1);

    clr_logs;
    do_start(1'b0, 32'd100, 32'd4097);
    check("rejcap_done", 64'(done_a), 64'd1);
    check("rejcap_err", 64'(err_a), 64'd1);
    tick; tick; tick;
    check("rejcap_reads", 64'(rises), 64'd0);

    clr_logs;
    sd_init_done = 1'b0;
    do_start(1'b0, 32'd100, 32'd16);
    check("noinit_busy", 64'(busy_a), 64'd0);
    tick; tick; tick;
    check("noinit_busy_late", 64'(busy_a), 64'd0);
    check("noinit_reads", 64'(rises), 64'd0);
    check("noinit_done_cnt", 64'(done_cnt), 64'd0);
    sd_init_done = 1'b1;

    // Abort during sector 0 of a 3-sector job
    clr_logs;
    do_start(1'b0, 32'd300, 32'd384);
    serve(100);
    tick; tick; tick;
    check("abort_reads", 64'(rises), 64'd1);
    check("abort_nwr", 64'(n_wr), 64'd128);
    check("abort_done_cnt", 64'(done_cnt), 64'd1);
    check("abort_err", 64'(err_last), 64'd1);

    // Reset in the middle of a transfer
    clr_logs;
    do_start(1'b0, 32'd100, 32'd200);
    tick;
    for (int i = 0; i < 50; i++) begin
      sd_valid = 1'b1;
      sd_data  = 8'(i);
      tick;
    end
    rst = 1'b0;
    sd_valid = 1'b0;
    #1;
    check("mrst_busy", 64'(busy_a), 64'd0);
    check("mrst_rd", 64'(rd_a), 64'd0);
    check("mrst_addr", 64'(rda_a), 64'd0);
    check("mrst_wr_data", 64'(wdata_a), 64'd0);
    check("mrst_wr_addr", 64'(waddr_a), 64'd0);
    tick; tick;
    rst = 1'b1;
    tick; tick; tick;
    check("mrst_no_done", 64'(done_cnt), 64'd0);

    clr_logs;
    do_start(1'b0, 32'd100, 32'd128);
    serve(-1);
    tick; tick;
    check("post_nwr", 64'(n_wr), 64'd128);
    check("post_w0", 64'(wd_log[0]), 64'h03020100);
    check("post_err", 64'(err_last), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_weight_loader.md
# sd_weight_loader

Parametrised SD-card weight loader for the convolution accelerator. It reads a contiguous run of 512-byte sectors through the sd_card_top sector-read port. It packs the byte stream into DATA_W-bit words and writes them round-robin into NUM_BANKS weight RAM banks. It replaces the fixed 24-bit, button-triggered BMP path with a host-commanded, width- and bank-configurable transfer that has completion and error status.

## Interface
Parameters:
- DATA_W, 32: output word width. Must be a multiple of 8, range 8..64. BYTES = DATA_W/8.
- NUM_BANKS, 4: number of weight banks. Power of two, 1..16. BANK_W = max(1, log2(NUM_BANKS)).
- ADDR_W, 10: word address width per bank. Capacity CAP = NUM_BANKS * 2^ADDR_W words.
- BYTE_ORDER, 0: 0 = first SD byte lands in word bits [7:0] (little-endian); 1 = first byte lands in the MSB byte.

Ports:
- clk, in, 1: system clock. Single clock domain.
- rst, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle command pulse.
- start_sector, in, 32: first SD sector address. Sampled on an accepted start.
- word_count, in, 32: number of words to load. Sampled on an accepted start.
- abort, in, 1: level or pulse that requests early termination.
- busy, out, 1: high from an accepted start until done.
- done, out, 1: one-cycle completion pulse.
- err, out, 1: valid with done. 1 = rejected or aborted.
- sd_init_done, in, 1: SD controller initialisation complete.
- sd_sec_read, out, 1: sector read request level.
- sd_sec_read_addr, out, 32: sector address. Stable while sd_sec_read is high.
- sd_sec_read_data, in, 8: read byte.
- sd_sec_read_data_valid, in, 1: byte strobe.
- sd_sec_read_end, in, 1: sector complete pulse.
- wr_en, out, 1: bank write strobe.
- wr_bank, out, BANK_W: target bank.
- wr_addr, out, ADDR_W: word address within the bank.
- wr_data, out, DATA_W: packed word.

## Operation
- States: IDLE, REQ, XFER, GAP, FIN.
- Start acceptance:
  - start is accepted only in IDLE with sd_init_done=1. Otherwise it is ignored, including start while busy.
  - If word_count==0 or word_count>CAP, the block goes to FIN with err=1 and issues no SD access.
  - Otherwise it latches its inputs and computes total_bytes = word_count*BYTES as a 40-bit value, and sectors = ceil(total_bytes/512). Then it enters REQ.
- REQ: drive sd_sec_read=1 and sd_sec_read_addr = start_sector + sec_idx (modulo 2^32). Move to XFER on the next cycle.
- XFER:
  - sd_sec_read stays high.
  - Each data_valid byte increments byte_cnt.
  - While byte_cnt < total_bytes, the byte is shifted into the pack register at its BYTE_ORDER position. Bytes beyond total_bytes, i.e. the tail of the last sector, are discarded.
  - Words span sector boundaries freely; the pack state is not reset between sectors.
  - When sd_sec_read_end arrives, move to GAP.
- GAP:
  - sd_sec_read=0 for exactly 1 cycle and sec_idx increments.
  - If abort was seen at any time since start, go to FIN with err=1.
  - Else if sec_idx+1 < sectors, go to REQ.
  - Else go to FIN with err=0.
- FIN: pulse done for 1 cycle with err, clear busy, return to IDLE.
- Word distribution: word k goes to wr_bank = k mod NUM_BANKS and wr_addr = k / NUM_BANKS.
- Abort handling:
  - Abort never cuts a sector mid-stream.
  - Words completed before the sector ends are still written.
  - A partially packed word is dropped.
- data_valid and sd_sec_read_end are ignored outside XFER.

## Timing
- Reset values: busy=0, done=0, err=0, sd_sec_read=0, sd_sec_read_addr=0, wr_en=0, wr_bank=0, wr_addr=0, wr_data=0. All internal counters are 0 and the FSM is in IDLE.
- Reset asserted mid-transfer aborts immediately. No done pulse is generated.
- The accepted start cycle is T. sd_sec_read rises at T+1 with a valid address.
- All outputs are registered. wr_en is high for exactly 1 cycle, in the cycle after the data_valid that completes a word. wr_bank, wr_addr and wr_data are valid only in that cycle.
- The final wr_en always precedes or coincides with the GAP cycle, and therefore precedes done.
- done occurs 2 cycles after the last sd_sec_read_end (GAP, then FIN). A rejected start gives done at T+1.
- Back-to-back sectors: sd_sec_read is low for exactly 1 cycle between sectors.
- The block has no backpressure. The weight RAM must accept one write per cycle.

## Test plan
- DATA_W=32, NUM_BANKS=4, start_sector=100, word_count=128 (exactly one sector), bytes 0..255 repeating:
  - Required: one read at address 100.
  - Word0 = 0x03020100 → bank0 addr0.
  - Word5 → bank1 addr1.
  - done with err=0.
- word_count=200 (800 bytes):
  - Required: reads at addresses 100 and 101 with a 1-cycle gap.
  - Exactly 200 wr_en pulses.
  - The last 224 bytes of sector 101 produce no writes.
- DATA_W=24, BYTE_ORDER=1, word_count=171:
  - Word170 spans sectors 0 and 1 (bytes 510..512).
  - Required: wr_data = {b510, b511, b0'} packed MSB-first.
- Rejections:
  - start with word_count=0 → done+err at T+1, no sd_sec_read.
  - word_count=CAP+1 → same.
  - start with sd_init_done=0 → ignored, busy stays 0.
- abort pulsed midway through sector 0 of a 3-sector job → sector 0 completes, no further read, done with err=1.
- rst deasserted to 0 (asserted) mid-XFER → all outputs return to reset values immediately, no done pulse. A new start after release runs normally.
